// File: rtl/cntr_mod_updn_if.sv
// Control and status bundle for the up/down modulo counter.
// The master drives the requests and the slave returns the count and status.
interface cntr_mod_updn_if #(
  parameter int rndw = 4
) ();
  logic            clr;
  logic            en;
  logic            c_up;
  logic            c_dn;
  logic            ld;
  logic [rndw-1:0] d;
  logic [rndw-1:0] q;
  logic            tc;
  logic            ovf;
  logic            udf;
  logic            zero;

  modport master (
    output clr, en, c_up, c_dn, ld, d,
    input  q, tc, ovf, udf, zero
  );

  modport slave (
    input  clr, en, c_up, c_dn, ld, d,
    output q, tc, ovf, udf, zero
  );
endinterface

// File: rtl/cntr_mod_updn.sv
// Up/down modulo counter with programmable modulus, parallel load, wrap or saturate,
// a terminal-count pulse and sticky overflow/underflow flags.
module cntr_mod_updn #(
  parameter int rndw = 4,
  parameter int MOD  = 1 << rndw,
  parameter int SAT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  cntr_mod_updn_if.slave   bus
);

  if (MOD < 2 || MOD > (1 << rndw)) begin : g_bad_mod
    $error("cntr_mod_updn: MOD must lie in 2..2**rndw");
  end

  localparam int              MODM1 = MOD - 1;
  localparam logic [rndw:0]   MOD_X = MOD[rndw:0];
  localparam logic [rndw:0]   TOP_X = MODM1[rndw:0];
  localparam logic [rndw-1:0] TOP   = MODM1[rndw-1:0];

  logic [rndw-1:0] q_q, q_d;
  logic            tc_q, tc_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;

  logic [rndw:0]   q_ext;
  logic [rndw:0]   d_ext;
  logic            at_top;
  logic            at_bot;
  logic            up;
  logic            dn;

  // One spare bit keeps MOD = 2**rndw exact in the range comparisons.
  assign q_ext  = {1'b0, q_q};
  assign d_ext  = {1'b0, bus.d};
  assign at_top = (q_ext == TOP_X);
  assign at_bot = (q_q == '0);
  assign up     = bus.en & bus.c_up & ~bus.c_dn;
  assign dn     = bus.en & bus.c_dn & ~bus.c_up;

  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (bus.clr) begin
      q_d   = '0;
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else if (bus.ld) begin
      q_d = (d_ext >= MOD_X) ? TOP : bus.d;
    end else if (up) begin
      if (at_top) begin
        q_d   = (SAT != 0) ? q_q : '0;
        tc_d  = 1'b1;
        ovf_d = 1'b1;
      end else begin
        q_d = q_q + 1'b1;
      end
    end else if (dn) begin
      if (at_bot) begin
        q_d   = (SAT != 0) ? q_q : TOP;
        tc_d  = 1'b1;
        udf_d = 1'b1;
      end else begin
        q_d = q_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.tc   = tc_q;
  assign bus.ovf  = ovf_q;
  assign bus.udf  = udf_q;
  assign bus.zero = at_bot;

endmodule
